// File: rtl/sdr_symbol_mapper_pkg.sv
// Shared types and helpers for the SDR transmit symbol mapper.
package sdr_symbol_mapper_pkg;

  localparam int unsigned SDR_MAX_SYM_W  = 12;
  localparam int unsigned SDR_SYM_SIZE_W = 4;
  localparam int unsigned SDR_SHIFT_W    = 2;
  localparam int unsigned SDR_GAINER_W   = 3;

  // Enumerator value equals the number of bits carried per symbol.
  typedef enum logic [3:0] {
    MOD_BPSK    = 4'd1,
    MOD_QPSK    = 4'd2,
    MOD_PSK8    = 4'd3,
    MOD_QAM16   = 4'd4,
    MOD_QAM32   = 4'd5,
    MOD_QAM64   = 4'd6,
    MOD_QAM128  = 4'd7,
    MOD_QAM256  = 4'd8,
    MOD_QAM512  = 4'd9,
    MOD_QAM1024 = 4'd10,
    MOD_QAM2048 = 4'd11,
    MOD_QAM4096 = 4'd12
  } t_modulation;

  // Static modulation table entry; gainer runs 1..4.
  typedef struct packed {
    t_modulation               modulation;
    logic [SDR_SYM_SIZE_W-1:0] symbol_size;
    logic [SDR_GAINER_W-1:0]   gainer;
  } t_modulation_settings;

  // Run-time mapper configuration: bits per symbol and output left shift.
  typedef struct packed {
    logic [SDR_SYM_SIZE_W-1:0] sym_size;
    logic [SDR_SHIFT_W-1:0]    shift;
  } t_mapper_cfg;

  localparam t_mapper_cfg SDR_CFG_RESET = '{sym_size: 4'd1, shift: 2'd0};

  // Translate a table entry into the mapper's run-time configuration.
  function automatic t_mapper_cfg to_mapper_cfg(input t_modulation_settings s);
    t_mapper_cfg c;
    c.sym_size = s.symbol_size;
    c.shift    = SDR_SHIFT_W'(s.gainer - SDR_GAINER_W'(1));
    return c;
  endfunction

  // Default table entry for a modulation: denser constellations get more gain.
  function automatic t_modulation_settings modulation_settings(input t_modulation m);
    t_modulation_settings s;
    s.modulation  = m;
    s.symbol_size = SDR_SYM_SIZE_W'(m);
    case (m)
      MOD_BPSK, MOD_QPSK, MOD_PSK8:         s.gainer = 3'd1;
      MOD_QAM16, MOD_QAM32, MOD_QAM64:      s.gainer = 3'd2;
      MOD_QAM128, MOD_QAM256, MOD_QAM512:   s.gainer = 3'd3;
      default:                              s.gainer = 3'd4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sdr_symbol_mapper_ram.sv
// Simple dual-port constellation LUT: read-first, registered read data.
module sdr_symbol_mapper_ram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Write port; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port; a same-edge write to the same address is seen on the next read.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdr_symbol_mapper.sv
// Bit-to-constellation mapper: byte gearbox -> I/Q LUT -> per-symbol gain with saturation.
module sdr_symbol_mapper
  import sdr_symbol_mapper_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_SYM_W = SDR_MAX_SYM_W,
  parameter int unsigned PLANE_W   = 16
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 icfg_update,
  input  logic [3:0]           icfg_sym_size,
  input  logic [1:0]           icfg_gainer,
  input  logic                 ilut_we,
  input  logic [MAX_SYM_W-1:0] ilut_addr,
  input  logic [PLANE_W-1:0]   ilut_i,
  input  logic [PLANE_W-1:0]   ilut_q,
  input  logic                 idata_valid,
  input  logic [DATA_W-1:0]    idata,
  output logic                 odata_ready,
  output logic                 osym_valid,
  input  logic                 isym_ready,
  output logic [MAX_SYM_W-1:0] osym_idx,
  output logic [PLANE_W-1:0]   osym_i,
  output logic [PLANE_W-1:0]   osym_q,
  output logic                 ocfg_err,
  output logic                 odrop
);

  localparam int unsigned ACC_W  = DATA_W + MAX_SYM_W - 1;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);
  localparam int unsigned EXT_W  = PLANE_W + 3;
  localparam int unsigned LUT_W  = 2 * PLANE_W;

  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((2 ** (PLANE_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_LO = -SAT_HI;

  // Sign-extend, shift left, clamp symmetrically to +/-(2**(PLANE_W-1)-1).
  function automatic logic [PLANE_W-1:0] sat_shift(input logic [PLANE_W-1:0] v,
                                                   input logic [1:0]         sh);
    logic signed [EXT_W-1:0] w;
    logic [PLANE_W-1:0]      r;
    w = $signed({{(EXT_W - PLANE_W){v[PLANE_W-1]}}, v});
    w = w <<< sh;
    if (w > SAT_HI) begin
      r = PLANE_W'(SAT_HI);
    end else if (w < SAT_LO) begin
      r = PLANE_W'(SAT_LO);
    end else begin
      r = PLANE_W'(w);
    end
    return r;
  endfunction

  // Configuration and status
  t_mapper_cfg cfg_q, cfg_d;
  logic        cfg_err_q, cfg_err_d;
  logic        drop_q, drop_d;
  logic        ready_en_q;

  // Gearbox: valid bits are left-aligned, bits below fill are always zero
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Pipeline stages
  logic                 s1_valid_q, s1_valid_d;
  logic [MAX_SYM_W-1:0] s1_idx_q, s1_idx_d;
  logic [1:0]           s1_shift_q, s1_shift_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [MAX_SYM_W-1:0] s2_idx_q, s2_idx_d;
  logic [1:0]           s2_shift_q, s2_shift_d;
  logic                 out_valid_q, out_valid_d;
  logic [MAX_SYM_W-1:0] out_idx_q, out_idx_d;
  logic [PLANE_W-1:0]   out_i_q, out_i_d;
  logic [PLANE_W-1:0]   out_q_q, out_q_d;

  // Combinational control
  logic                 en_c;
  logic                 cfg_ok_c;
  logic                 cfg_apply_c;
  logic                 ready_c;
  logic                 take_c;
  logic                 ext_c;
  logic [FILL_W-1:0]    sym_n_c;
  logic [MAX_SYM_W-1:0] ext_idx_c;
  logic [ACC_W-1:0]     acc_ext_c;
  logic [FILL_W-1:0]    fill_ext_c;
  logic [ACC_W-1:0]     word_al_c;
  logic [LUT_W-1:0]     lut_rdata;

  assign en_c        = !out_valid_q || isym_ready;
  assign cfg_ok_c    = (icfg_sym_size != 4'd0) && (32'(icfg_sym_size) <= MAX_SYM_W);
  assign cfg_apply_c = icfg_update && cfg_ok_c;
  assign ready_c     = ready_en_q && ((32'(fill_q) + DATA_W) <= ACC_W) && !icfg_update;
  assign take_c      = idata_valid && ready_c;
  assign sym_n_c     = FILL_W'(cfg_q.sym_size);
  assign ext_c       = en_c && !cfg_apply_c && (fill_q >= sym_n_c);
  assign ext_idx_c   = MAX_SYM_W'(acc_q >> (ACC_W - 32'(cfg_q.sym_size)));
  assign word_al_c   = ACC_W'(idata) << (ACC_W - DATA_W);

  // Constellation LUT, packed as {I, Q}; read advances with the pipeline.
  sdr_symbol_mapper_ram #(
    .ADDR_W (MAX_SYM_W),
    .WORD_W (LUT_W)
  ) u_const_ram (
    .clk_i   (iclk),
    .we_i    (ilut_we),
    .waddr_i (ilut_addr),
    .wdata_i ({ilut_i, ilut_q}),
    .re_i    (en_c),
    .raddr_i (s1_idx_q),
    .rdata_o (lut_rdata)
  );

  // Config update: accept valid sizes, flag bad ones, discard buffered bits.
  always_comb begin
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    drop_d    = 1'b0;
    if (cfg_apply_c) begin
      cfg_d.sym_size = icfg_sym_size;
      cfg_d.shift    = icfg_gainer;
      drop_d         = (fill_q != '0);
    end
    if (icfg_update && !cfg_ok_c) begin
      cfg_err_d = 1'b1;
    end
  end

  // Gearbox: extract from the top, append the new word just below what remains.
  always_comb begin
    acc_ext_c  = acc_q;
    fill_ext_c = fill_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    if (ext_c) begin
      acc_ext_c  = acc_q << cfg_q.sym_size;
      fill_ext_c = fill_q - sym_n_c;
    end
    if (cfg_apply_c) begin
      acc_d  = '0;
      fill_d = '0;
    end else begin
      acc_d  = acc_ext_c;
      fill_d = fill_ext_c;
      if (take_c) begin
        acc_d  = acc_ext_c | (word_al_c >> fill_ext_c);
        fill_d = fill_ext_c + FILL_W'(DATA_W);
      end
    end
  end

  // Pipeline advance: every stage holds while the output is stalled.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_idx_d    = s1_idx_q;
    s1_shift_d  = s1_shift_q;
    s2_valid_d  = s2_valid_q;
    s2_idx_d    = s2_idx_q;
    s2_shift_d  = s2_shift_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    if (en_c) begin
      s1_valid_d = ext_c;
      if (ext_c) begin
        s1_idx_d   = ext_idx_c;
        s1_shift_d = cfg_q.shift;
      end
      s2_valid_d  = s1_valid_q;
      s2_idx_d    = s1_idx_q;
      s2_shift_d  = s1_shift_q;
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_idx_d = s2_idx_q;
        out_i_d   = sat_shift(lut_rdata[LUT_W-1 -: PLANE_W], s2_shift_q);
        out_q_d   = sat_shift(lut_rdata[PLANE_W-1:0], s2_shift_q);
      end
    end
  end

  // State registers with synchronous reset; a reset flushes gearbox and pipeline.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      cfg_q       <= SDR_CFG_RESET;
      cfg_err_q   <= 1'b0;
      drop_q      <= 1'b0;
      ready_en_q  <= 1'b0;
      acc_q       <= '0;
      fill_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_shift_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_idx_q    <= '0;
      s2_shift_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      cfg_q       <= cfg_d;
      cfg_err_q   <= cfg_err_d;
      drop_q      <= drop_d;
      ready_en_q  <= 1'b1;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      s1_shift_q  <= s1_shift_d;
      s2_valid_q  <= s2_valid_d;
      s2_idx_q    <= s2_idx_d;
      s2_shift_q  <= s2_shift_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

  assign odata_ready = ready_c;
  assign osym_valid  = out_valid_q;
  assign osym_idx    = out_idx_q;
  assign osym_i      = out_i_q;
  assign osym_q      = out_q_q;
  assign ocfg_err    = cfg_err_q;
  assign odrop       = drop_q;

endmodule

// File: tb/tb_sdr_symbol_mapper.sv
// Scoreboard bench for sdr_symbol_mapper against a bit-queue reference model.
module tb_sdr_symbol_mapper;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_SYM_W = 12;
  localparam int unsigned PLANE_W   = 16;
  localparam int          DEPTH     = 4096;

  logic                 iclk = 1'b0;
  logic                 ireset;
  logic                 icfg_update;
  logic [3:0]           icfg_sym_size;
  logic [1:0]           icfg_gainer;
  logic                 ilut_we;
  logic [MAX_SYM_W-1:0] ilut_addr;
  logic [PLANE_W-1:0]   ilut_i;
  logic [PLANE_W-1:0]   ilut_q;
  logic                 idata_valid;
  logic [DATA_W-1:0]    idata;
  logic                 odata_ready;
  logic                 osym_valid;
  logic                 isym_ready = 1'b1;
  logic [MAX_SYM_W-1:0] osym_idx;
  logic [PLANE_W-1:0]   osym_i;
  logic [PLANE_W-1:0]   osym_q;
  logic                 ocfg_err;
  logic                 odrop;

  sdr_symbol_mapper #(
    .DATA_W    (DATA_W),
    .MAX_SYM_W (MAX_SYM_W),
    .PLANE_W   (PLANE_W)
  ) dut (
    .iclk          (iclk),
    .ireset        (ireset),
    .icfg_update   (icfg_update),
    .icfg_sym_size (icfg_sym_size),
    .icfg_gainer   (icfg_gainer),
    .ilut_we       (ilut_we),
    .ilut_addr     (ilut_addr),
    .ilut_i        (ilut_i),
    .ilut_q        (ilut_q),
    .idata_valid   (idata_valid),
    .idata         (idata),
    .odata_ready   (odata_ready),
    .osym_valid    (osym_valid),
    .isym_ready    (isym_ready),
    .osym_idx      (osym_idx),
    .osym_i        (osym_i),
    .osym_q        (osym_q),
    .ocfg_err      (ocfg_err),
    .odrop         (odrop)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int idx;
    int i;
    int q;
  } exp_t;

  exp_t exp_q[$];
  bit   bitq[$];
  int   lut_i[DEPTH];
  int   lut_q[DEPTH];
  int   cur_size  = 1;
  int   cur_shift = 0;
  int   cur_err   = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   acc_cyc   = 0;
  bit   lat_pending = 1'b0;
  bit   rand_ready  = 1'b0;
  int   sym_seen  = 0;

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Gain then symmetric clamp, in plain integer arithmetic.
  function automatic int sat_ref(input int v, input int sh);
    int w;
    w = v * (1 << sh);
    if (w > 32767) w = 32767;
    if (w < -32767) w = -32767;
    return w;
  endfunction

  // Append a word MSB-first and cut out every complete symbol.
  function automatic void push_word(input logic [7:0] w);
    exp_t e;
    int   idx;
    for (int b = 7; b >= 0; b--) bitq.push_back(w[b]);
    while (bitq.size() >= cur_size) begin
      idx = 0;
      for (int k = 0; k < cur_size; k++) idx = idx * 2 + int'(bitq.pop_front());
      e.idx = idx;
      e.i   = sat_ref(lut_i[idx], cur_shift);
      e.q   = sat_ref(lut_q[idx], cur_shift);
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: output must match the scoreboard head every valid cycle; pop on transfer.
  always @(negedge iclk) begin
    if (ireset === 1'b0 && osym_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_symbol: got idx %0d, expected no symbol", osym_idx);
      end else begin
        check("sym_idx", osym_idx, exp_q[0].idx);
        check("sym_i", $signed(osym_i), exp_q[0].i);
        check("sym_q", $signed(osym_q), exp_q[0].q);
        if (lat_pending) begin
          check("latency", cyc - acc_cyc, 3);
          lat_pending = 1'b0;
        end
        if (isym_ready === 1'b1) begin
          void'(exp_q.pop_front());
          sym_seen++;
        end
      end
    end
  end

  // Downstream ready: random while rand_ready is set, otherwise always accepting.
  always begin
    @(posedge iclk);
    #1;
    isym_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic lut_write(input int a, input int vi, input int vq);
    ilut_we   = 1'b1;
    ilut_addr = MAX_SYM_W'(a);
    ilut_i    = PLANE_W'(vi);
    ilut_q    = PLANE_W'(vq);
    lut_i[a]  = vi;
    lut_q[a]  = vq;
    @(posedge iclk);
    #1;
    ilut_we = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit want_lat, output int waits);
    idata       = w;
    idata_valid = 1'b1;
    waits       = 0;
    @(negedge iclk);
    while (odata_ready !== 1'b1 && waits < 200) begin
      waits++;
      @(negedge iclk);
    end
    if (waits >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got odata_ready %0b for 200 cycles, expected 1", odata_ready);
      idata_valid = 1'b0;
    end else begin
      @(posedge iclk);
      #1;
      push_word(w);
      if (want_lat) begin
        acc_cyc     = cyc;
        lat_pending = 1'b1;
      end
      idata_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge iclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d symbols pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge iclk);
    #1;
  endtask

  task automatic do_cfg(input int size, input int shift);
    bit ok;
    int exp_drop;
    drain();
    ok            = (size >= 1) && (size <= 12);
    exp_drop      = (ok && bitq.size() != 0) ? 1 : 0;
    icfg_update   = 1'b1;
    icfg_sym_size = 4'(size);
    icfg_gainer   = 2'(shift);
    if (ok) begin
      bitq.delete();
      cur_size  = size;
      cur_shift = shift;
    end else begin
      cur_err = 1;
    end
    @(posedge iclk);
    #1;
    icfg_update = 1'b0;
    @(negedge iclk);
    check("odrop_on_update", odrop, exp_drop);
    check("ocfg_err", ocfg_err, cur_err);
    @(negedge iclk);
    check("odrop_one_cycle", odrop, 0);
    @(posedge iclk);
    #1;
  endtask

  initial begin
    int w;
    int s0;
    ireset        = 1'b1;
    icfg_update   = 1'b0;
    icfg_sym_size = 4'd1;
    icfg_gainer   = 2'd0;
    ilut_we       = 1'b0;
    ilut_addr     = '0;
    ilut_i        = '0;
    ilut_q        = '0;
    idata_valid   = 1'b0;
    idata         = '0;

    // Reset state
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    check("rst_osym_valid", osym_valid, 0);
    check("rst_odrop", odrop, 0);
    check("rst_ocfg_err", ocfg_err, 0);
    check("rst_osym_idx", osym_idx, 0);
    check("rst_osym_i", $signed(osym_i), 0);
    check("rst_osym_q", $signed(osym_q), 0);
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    @(negedge iclk);
    @(negedge iclk);
    check("ready_after_reset", odata_ready, 1);
    @(posedge iclk);
    #1;

    // Random contents for the whole LUT
    for (int a = 0; a < DEPTH; a++)
      lut_write(a, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);

    // QPSK, LUT[k] = {k*100, -k*100}, first symbol latency
    for (int k = 0; k < 4; k++) lut_write(k, k * 100, -k * 100);
    do_cfg(2, 0);
    send_word(8'hB4, 1'b1, w);
    drain();

    // Size 3 across word boundaries; ready gaps of at most one beat
    do_cfg(3, 0);
    send_word(8'hFF, 1'b0, w);
    send_word(8'h00, 1'b0, w);
    check("ready_gap_word2", int'(w > 1), 0);
    send_word(8'hFF, 1'b0, w);
    check("ready_gap_word3", int'(w > 1), 0);
    drain();

    // Saturation with shift 1, I and Q clamp independently
    lut_write(0, 20480, 256);
    lut_write(1, -24576, 28672);
    do_cfg(1, 1);
    send_word(8'h55, 1'b0, w);
    drain();

    // QAM4096 with random backpressure and random input gaps
    do_cfg(12, 2);
    s0 = sym_seen;
    rand_ready = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      send_word(8'($urandom), 1'b0, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge iclk);
        #1;
      end
    end
    rand_ready = 1'b0;
    drain();
    check("qam4096_symbol_count", sym_seen - s0, 1000);

    // Residual bits dropped on update
    do_cfg(5, 0);
    send_word(8'hC7, 1'b0, w);
    drain();
    do_cfg(4, 0);
    send_word(8'hA5, 1'b0, w);
    drain();

    // Oversized config is rejected, mapping continues at the old size
    do_cfg(13, 0);
    send_word(8'h3C, 1'b0, w);
    drain();

    // Reset in the middle of a burst
    do_cfg(1, 0);
    send_word(8'hE1, 1'b0, w);
    send_word(8'h5A, 1'b0, w);
    send_word(8'h0F, 1'b0, w);
    ireset = 1'b1;
    exp_q.delete();
    bitq.delete();
    cur_size    = 1;
    cur_shift   = 0;
    cur_err     = 0;
    lat_pending = 1'b0;
    @(posedge iclk);
    @(negedge iclk);
    check("midrst_osym_valid", osym_valid, 0);
    check("midrst_ocfg_err", ocfg_err, 0);
    check("midrst_osym_idx", osym_idx, 0);
    check("midrst_osym_i", $signed(osym_i), 0);
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    send_word(8'h96, 1'b0, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
